// File: rtl/reg_port_arbiter.sv
// Two-requester arbiter in front of a register bank with one write port and one read port.
// Optional REG_ARB_ROUND_ROBIN_EN: ties alternate between requesters instead of favouring A.
module reg_port_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_resp_valid,
  input  logic              b_valid,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] reg_write_address,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_read_address,
  output logic              reg_read,
  input  logic [DATA_W-1:0] reg_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdData} state_e;

  state_e              state_q;
  logic                id_b_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                reg_write_q;
  logic                reg_read_q;
  logic                a_resp_valid_q;
  logic                b_resp_valid_q;

  logic                idle;
  logic                grant_b;
  logic                accept;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

`ifdef REG_ARB_ROUND_ROBIN_EN
  logic last_b_q;
  // On a tie, B wins only if A was granted most recently.
  assign grant_b = b_valid && (!a_valid || !last_b_q);
`else
  assign grant_b = b_valid && !a_valid;
`endif

  // Gating with reset keeps a request from being accepted while state is being cleared.
  assign idle    = (state_q == StIdle) && !reset;
  assign a_ready = idle && a_valid && !grant_b;
  assign b_ready = idle && grant_b;
  assign accept  = a_ready || b_ready;

  assign sel_write = grant_b ? b_write : a_write;
  assign sel_addr  = grant_b ? b_addr  : a_addr;
  assign sel_wdata = grant_b ? b_wdata : a_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      id_b_q         <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      reg_write_q    <= 1'b0;
      reg_read_q     <= 1'b0;
      a_resp_valid_q <= 1'b0;
      b_resp_valid_q <= 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
      last_b_q       <= 1'b1;
`endif
    end else begin
      reg_write_q    <= 1'b0;
      reg_read_q     <= 1'b0;
      a_resp_valid_q <= 1'b0;
      b_resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            id_b_q  <= grant_b;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
`ifdef REG_ARB_ROUND_ROBIN_EN
            last_b_q <= grant_b;
`endif
            if (sel_write) begin
              state_q <= StWrite;
              // Address 0 is hardwired zero: walk the FSM but never strobe the bank.
              reg_write_q <= (sel_addr != '0);
            end else begin
              state_q    <= StRead;
              reg_read_q <= 1'b1;
            end
          end
        end
        StWrite: state_q <= StIdle;
        StRead: begin
          state_q        <= StRdData;
          a_resp_valid_q <= !id_b_q;
          b_resp_valid_q <= id_b_q;
        end
        StRdData: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign reg_write         = reg_write_q;
  assign reg_write_address = addr_q;
  assign reg_write_data    = wdata_q;
  assign reg_read          = reg_read_q;
  assign reg_read_address  = addr_q;
  assign a_resp_valid      = a_resp_valid_q;
  assign b_resp_valid      = b_resp_valid_q;
  assign busy              = (state_q != StIdle);

  // Bank data arrives in RD_DATA itself, so it is passed through rather than registered.
  assign resp_data = ((state_q == StRdData) && (addr_q != '0)) ? reg_read_data : '0;

endmodule
